// File: rtl/apb_rr_master.sv
// apb_rr_master
//   Two-requester APB master. Arbitrates round-robin between two internal
//   clients and runs each accepted request through the slave's
//   SETUP/ACCESS sequence. Reads take one extra CAPTURE cycle, because the
//   slave registers prdata one edge after ACCESS.
//
// Handshake: a request is taken on a rising edge where
//   req_valid[i] & req_ready[i]. req_valid must stay high until accepted, and
//   the request fields must be stable while req_valid is high. rsp_valid[i] is
//   a one-cycle pulse back to the requester that issued the transfer.
//
// Ports
//   clk, reset             rising-edge clock, async active-low reset
//   req_valid/req_write    per-requester valid / direction (1 = write)
//   req_addr/req_wdata     packed per requester, slot i at [i*W +: W]
//   req_ready              accept, at most one bit high
//   rsp_valid/rsp_rdata    completion pulse and read data (0 for writes)
//   busy                   high whenever the FSM is not IDLE
//   psel..pwdata, prdata   APB master signals
//   dbg_state              current FSM state (0 IDLE, 1 SETUP, 2 ACCESS, 3 CAPTURE)
module apb_rr_master #(
  parameter int ADDR_W  = 8,
  parameter int WDATA_W = 8,
  parameter int RDATA_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [1:0]           req_write,
  input  logic [2*ADDR_W-1:0]  req_addr,
  input  logic [2*WDATA_W-1:0] req_wdata,
  output logic [1:0]           rsp_valid,
  output logic [RDATA_W-1:0]   rsp_rdata,
  output logic                 busy,
  output logic                 psel,
  output logic                 penable,
  output logic                 pwrite,
  output logic [ADDR_W-1:0]    paddr,
  output logic [WDATA_W-1:0]   pwdata,
  input  logic [RDATA_W-1:0]   prdata,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_ACCESS  = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   last_grant_q;
  logic   owner_q;
  logic   win;
  logic   accept_pt;
  logic   accept;
  logic   done_wr;
  logic   done_rd;

  // Winner: a lone valid requester wins; on a tie the one that was not
  // granted last time wins.
  always_comb begin
    if (req_valid == 2'b11) win = ~last_grant_q;
    else                    win = req_valid[1];
  end

  // New requests are taken only where the bus becomes free on the next cycle.
  assign accept_pt = (state_q == ST_IDLE) ||
                     ((state_q == ST_ACCESS) && pwrite) ||
                     (state_q == ST_CAPTURE);

  // Gated by reset so that req_ready drops the moment reset asserts.
  always_comb begin
    req_ready = 2'b00;
    if (accept_pt && reset && (req_valid != 2'b00))
      req_ready = win ? 2'b10 : 2'b01;
  end

  assign accept  = |(req_valid & req_ready);
  assign done_wr = (state_q == ST_ACCESS) && pwrite;
  assign done_rd = (state_q == ST_CAPTURE);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    state_d = accept ? ST_SETUP : ST_IDLE;
      ST_SETUP:   state_d = ST_ACCESS;
      ST_ACCESS:  begin
        if (!pwrite)     state_d = ST_CAPTURE;
        else if (accept) state_d = ST_SETUP;
        else             state_d = ST_IDLE;
      end
      ST_CAPTURE: state_d = accept ? ST_SETUP : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the registered state
  always_comb begin
    psel      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    penable   = (state_q == ST_ACCESS);
    busy      = (state_q != ST_IDLE);
    dbg_state = state_q;
  end

  // Request capture. paddr/pwrite/pwdata hold their last values while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      pwrite       <= 1'b0;
      paddr        <= '0;
      pwdata       <= '0;
    end else if (accept) begin
      last_grant_q <= win;
      owner_q      <= win;
      pwrite       <= req_write[win];
      paddr        <= win ? req_addr[2*ADDR_W-1:ADDR_W]   : req_addr[ADDR_W-1:0];
      pwdata       <= win ? req_wdata[2*WDATA_W-1:WDATA_W] : req_wdata[WDATA_W-1:0];
    end
  end

  // Completion: pulse the cycle after the transfer's last bus cycle.
  // rsp_rdata holds until the next completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid <= 2'b00;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 2'b00;
      if (done_wr || done_rd)
        rsp_valid <= owner_q ? 2'b10 : 2'b01;
      if (done_wr) rsp_rdata <= '0;
      if (done_rd) rsp_rdata <= prdata;
    end
  end

endmodule

// File: tb/tb_apb_rr_master.sv
module tb_apb_rr_master;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_write;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  rsp_valid;
  logic [3:0]  rsp_rdata;
  logic        busy;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [7:0]  pwdata;
  logic [3:0]  prdata;
  logic [1:0]  dbg_state;

  int n_cmp;
  int n_err;

  apb_rr_master #(.ADDR_W(8), .WDATA_W(8), .RDATA_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // APB slave model: memory of bytes, read data is the low nibble,
  // registered on the ACCESS edge.
  logic [7:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    prdata = 4'h0;
  end
  always @(posedge clk) begin
    if (psel && penable) begin
      if (pwrite) mem[paddr] <= pwdata;
      else        prdata     <= mem[paddr][3:0];
    end
  end

  typedef struct {
    logic [1:0] v;
    logic [1:0] w;
    logic [7:0] a0, a1, d0, d1;
    logic [1:0] rdy;
    logic       ps, pe, pw;
    logic [7:0] pa, pd;
    logic [1:0] rv;
    logic [3:0] rd;
    logic       bz;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [1:0] v, logic [1:0] w,
                              logic [7:0] a0, logic [7:0] a1,
                              logic [7:0] d0, logic [7:0] d1,
                              logic [1:0] rdy, logic ps, logic pe, logic pw,
                              logic [7:0] pa, logic [7:0] pd,
                              logic [1:0] rv, logic [3:0] rd, logic bz);
    vec_t t;
    t.v = v; t.w = w; t.a0 = a0; t.a1 = a1; t.d0 = d0; t.d1 = d1;
    t.rdy = rdy; t.ps = ps; t.pe = pe; t.pw = pw; t.pa = pa; t.pd = pd;
    t.rv = rv; t.rd = rd; t.bz = bz;
    return t;
  endfunction

  // Driver tasks
  task automatic drive(input logic [1:0] v, input logic [1:0] w,
                       input logic [7:0] a0, input logic [7:0] a1,
                       input logic [7:0] d0, input logic [7:0] d1);
    req_valid = v;
    req_write = w;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_vec(input int idx, input vec_t t);
    string p;
    p = $sformatf("vec%0d", idx);
    chk({p, ".req_ready"}, 32'(req_ready), 32'(t.rdy));
    chk({p, ".psel"},      32'(psel),      32'(t.ps));
    chk({p, ".penable"},   32'(penable),   32'(t.pe));
    chk({p, ".pwrite"},    32'(pwrite),    32'(t.pw));
    chk({p, ".paddr"},     32'(paddr),     32'(t.pa));
    chk({p, ".pwdata"},    32'(pwdata),    32'(t.pd));
    chk({p, ".rsp_valid"}, 32'(rsp_valid), 32'(t.rv));
    chk({p, ".rsp_rdata"}, 32'(rsp_rdata), 32'(t.rd));
    chk({p, ".busy"},      32'(busy),      32'(t.bz));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;

    //               v     w     a0     a1     d0     d1     rdy  ps pe pw pa     pd     rv    rd    bz
    // write r0 0x10<=A5, then r1 read 0x10 back-to-back, then r0 write 0x20
    vecs.push_back(mk(2'b01,2'b01,8'h10,8'h00,8'hA5,8'h00, 2'b01,0,0,0,8'h00,8'h00,2'b00,4'h0,0));
    vecs.push_back(mk(2'b00,2'b01,8'h10,8'h00,8'hA5,8'h00, 2'b00,1,0,1,8'h10,8'hA5,2'b00,4'h0,1));
    vecs.push_back(mk(2'b10,2'b00,8'h10,8'h10,8'hA5,8'h00, 2'b10,1,1,1,8'h10,8'hA5,2'b00,4'h0,1));
    vecs.push_back(mk(2'b00,2'b00,8'h10,8'h10,8'hA5,8'h00, 2'b00,1,0,0,8'h10,8'h00,2'b01,4'h0,1));
    vecs.push_back(mk(2'b01,2'b01,8'h20,8'h10,8'h3C,8'h00, 2'b00,1,1,0,8'h10,8'h00,2'b00,4'h0,1));
    vecs.push_back(mk(2'b01,2'b01,8'h20,8'h10,8'h3C,8'h00, 2'b01,0,0,0,8'h10,8'h00,2'b00,4'h0,1));
    vecs.push_back(mk(2'b00,2'b01,8'h20,8'h10,8'h3C,8'h00, 2'b00,1,0,1,8'h20,8'h3C,2'b10,4'h5,1));
    vecs.push_back(mk(2'b00,2'b01,8'h20,8'h10,8'h3C,8'h00, 2'b00,1,1,1,8'h20,8'h3C,2'b00,4'h5,1));
    vecs.push_back(mk(2'b00,2'b01,8'h20,8'h10,8'h3C,8'h00, 2'b00,0,0,1,8'h20,8'h3C,2'b01,4'h0,0));
    vecs.push_back(mk(2'b00,2'b01,8'h20,8'h10,8'h3C,8'h00, 2'b00,0,0,1,8'h20,8'h3C,2'b00,4'h0,0));
    // both requesters continuously writing: grants alternate 1,0,1
    vecs.push_back(mk(2'b11,2'b11,8'h30,8'h40,8'h11,8'h22, 2'b10,0,0,1,8'h20,8'h3C,2'b00,4'h0,0));
    vecs.push_back(mk(2'b11,2'b11,8'h30,8'h40,8'h11,8'h22, 2'b00,1,0,1,8'h40,8'h22,2'b00,4'h0,1));
    vecs.push_back(mk(2'b11,2'b11,8'h30,8'h40,8'h11,8'h22, 2'b01,1,1,1,8'h40,8'h22,2'b00,4'h0,1));
    vecs.push_back(mk(2'b11,2'b11,8'h30,8'h40,8'h11,8'h22, 2'b00,1,0,1,8'h30,8'h11,2'b10,4'h0,1));
    vecs.push_back(mk(2'b11,2'b11,8'h30,8'h40,8'h11,8'h22, 2'b10,1,1,1,8'h30,8'h11,2'b00,4'h0,1));
    vecs.push_back(mk(2'b11,2'b11,8'h30,8'h40,8'h11,8'h22, 2'b00,1,0,1,8'h40,8'h22,2'b01,4'h0,1));
    vecs.push_back(mk(2'b00,2'b11,8'h30,8'h40,8'h11,8'h22, 2'b00,1,1,1,8'h40,8'h22,2'b00,4'h0,1));
    vecs.push_back(mk(2'b00,2'b11,8'h30,8'h40,8'h11,8'h22, 2'b00,0,0,1,8'h40,8'h22,2'b10,4'h0,0));
    // five idle cycles: everything holds
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(2'b00,2'b11,8'h30,8'h40,8'h11,8'h22, 2'b00,0,0,1,8'h40,8'h22,2'b00,4'h0,0));
    // r0 reads 0x40 (holds 0x22): rdata 2, four cycles after acceptance
    vecs.push_back(mk(2'b01,2'b00,8'h40,8'h40,8'h11,8'h22, 2'b01,0,0,1,8'h40,8'h22,2'b00,4'h0,0));
    vecs.push_back(mk(2'b00,2'b00,8'h40,8'h40,8'h11,8'h22, 2'b00,1,0,0,8'h40,8'h11,2'b00,4'h0,1));
    vecs.push_back(mk(2'b00,2'b00,8'h40,8'h40,8'h11,8'h22, 2'b00,1,1,0,8'h40,8'h11,2'b00,4'h0,1));
    vecs.push_back(mk(2'b00,2'b00,8'h40,8'h40,8'h11,8'h22, 2'b00,0,0,0,8'h40,8'h11,2'b00,4'h0,1));
    vecs.push_back(mk(2'b00,2'b00,8'h40,8'h40,8'h11,8'h22, 2'b00,0,0,0,8'h40,8'h11,2'b01,4'h2,0));
    vecs.push_back(mk(2'b00,2'b00,8'h40,8'h40,8'h11,8'h22, 2'b00,0,0,0,8'h40,8'h11,2'b00,4'h2,0));

    // Reset state, with both requesters valid during reset
    reset = 1'b0;
    drive(2'b11, 2'b11, 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst.req_ready", 32'(req_ready), 32'h0);
    chk("rst.psel",      32'(psel),      32'h0);
    chk("rst.penable",   32'(penable),   32'h0);
    chk("rst.busy",      32'(busy),      32'h0);
    chk("rst.rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst.paddr",     32'(paddr),     32'h0);
    chk("rst.pwdata",    32'(pwdata),    32'h0);
    chk("rst.rsp_rdata", 32'(rsp_rdata), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Table: drive at the negedge, check 1ns later, before the next posedge
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].v, vecs[i].w, vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
      #1;
      chk_vec(i, vecs[i]);
      @(negedge clk);
    end

    // Reset during ACCESS of a read from r1 (last_grant is 0 here)
    drive(2'b10, 2'b00, 8'h00, 8'h30, 8'h00, 8'h22);
    #1;
    chk("rr.ready_r1", 32'(req_ready), 32'h2);
    @(negedge clk);
    drive(2'b00, 2'b00, 8'h00, 8'h30, 8'h00, 8'h22);
    @(negedge clk);
    drive(2'b11, 2'b11, 8'h50, 8'h60, 8'h77, 8'h66);
    #1;
    chk("rr.access_psel",    32'(psel),    32'h1);
    chk("rr.access_penable", 32'(penable), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("rr.mid_psel",      32'(psel),      32'h0);
    chk("rr.mid_penable",   32'(penable),   32'h0);
    chk("rr.mid_busy",      32'(busy),      32'h0);
    chk("rr.mid_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rr.mid_req_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rr.post_ready_r0", 32'(req_ready), 32'h1);
    chk("rr.post_busy",     32'(busy),      32'h0);
    chk("rr.post_rsp",      32'(rsp_valid), 32'h0);
    @(negedge clk);
    drive(2'b00, 2'b11, 8'h50, 8'h60, 8'h77, 8'h66);
    #1;
    chk("rr.setup_psel",   32'(psel),   32'h1);
    chk("rr.setup_paddr",  32'(paddr),  32'h50);
    chk("rr.setup_pwdata", 32'(pwdata), 32'h77);
    chk("rr.setup_rsp",    32'(rsp_valid), 32'h0);
    @(negedge clk);
    #1;
    chk("rr.access_rsp", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    #1;
    chk("rr.done_rsp",   32'(rsp_valid), 32'h1);
    chk("rr.done_rdata", 32'(rsp_rdata), 32'h0);
    chk("rr.done_busy",  32'(busy),      32'h0);
    chk("rr.mem50",      32'(mem[8'h50]), 32'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
